// File: rtl/wreg_dst_pipe.sv
// wreg_dst_pipe: write-destination pipeline for the pipelined MIPS core.
//
// Decodes the destination register of the instruction leaving D (Rd / Rt /
// link / none). It carries {dst, vld} through STAGES slots (slot 0 = E,
// slot STAGES-1 = W) with stall and flush. From the registered slots it
// derives forwarding selects for two source operands, so that the hazard
// unit and the bypass muxes share one view of in-flight writes.
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset, clears every slot
//   stall      hold slot 0, inject a bubble into slot 1
//   flush      inject a bubble into slot 0 (wins over stall for slot 0)
//   in_valid   instruction leaving D is real
//   rt, rd     Rt / Rd fields of the instruction leaving D
//   regdst     00 Rd, 01 Rt, 10 LINK_REG, 11 no write
//   src_a/b    source registers queried for forwarding
//   dst_flat   slot k destination at [k*AW +: AW]
//   dst_vld    slot k holds a register write
//   fwd_a/b_sel  0 = no forward, k+1 = take slot k (youngest match)

module wreg_dst_pipe #(
  parameter int unsigned AW       = 5,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LINK_REG = 31,
  localparam int unsigned SW      = $clog2(STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [AW-1:0]          rt,
  input  logic [AW-1:0]          rd,
  input  logic [1:0]             regdst,
  input  logic [AW-1:0]          src_a,
  input  logic [AW-1:0]          src_b,
  output logic [STAGES*AW-1:0]   dst_flat,
  output logic [STAGES-1:0]      dst_vld,
  output logic [SW-1:0]          fwd_a_sel,
  output logic [SW-1:0]          fwd_b_sel
);

  logic [STAGES-1:0][AW-1:0] dst_q, dst_d;
  logic [STAGES-1:0]         vld_q, vld_d;

  logic [AW-1:0] new_dst;
  logic          new_vld;

  // Destination decode. A "write" to register 0 is recorded as dst 0 but
  // never marked valid, so it can never be forwarded.
  always_comb begin
    new_dst = '0;
    unique case (regdst)
      2'b00:   new_dst = rd;
      2'b01:   new_dst = rt;
      2'b10:   new_dst = AW'(LINK_REG);
      default: new_dst = '0;
    endcase
    new_vld = in_valid && (regdst != 2'b11) && (new_dst != '0);
  end

  // Slot advance. Flush only affects slot 0, so older instructions are never
  // killed; with flush and stall together, slot 1 still takes slot 0's old
  // contents.
  always_comb begin
    dst_d = dst_q;
    vld_d = vld_q;
    if (flush) begin
      dst_d[0] = '0;
      vld_d[0] = 1'b0;
    end else if (!stall) begin
      dst_d[0] = new_dst;
      vld_d[0] = new_vld;
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (k == 1 && stall && !flush) begin
        dst_d[k] = '0;
        vld_d[k] = 1'b0;
      end else begin
        dst_d[k] = dst_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dst_q <= '0;
      vld_q <= '0;
    end else begin
      dst_q <= dst_d;
      vld_q <= vld_d;
    end
  end

  // Youngest (lowest-index) valid slot whose destination equals src.
  function automatic logic [SW-1:0] fwd_sel(input logic [AW-1:0] src);
    logic [SW-1:0] sel;
    logic          found;
    sel   = '0;
    found = 1'b0;
    if (src != '0) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (!found && vld_q[k] && (dst_q[k] == src)) begin
          sel   = SW'(k + 1);
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_sel = fwd_sel(src_a);
    fwd_b_sel = fwd_sel(src_b);
  end

  assign dst_flat = dst_q;
  assign dst_vld  = vld_q;

endmodule

// File: tb/tb_wreg_dst_pipe.sv
// Testbench for wreg_dst_pipe. Three instances share stimulus: the default
// configuration (AW 5, STAGES 3, LINK 31), and AW 6 / LINK 63 with STAGES 1
// and STAGES 5. Directed scenarios exercise the default instance; a random
// phase drives all three against a slot-list reference model through
// per-instance scoreboards checked by a negedge monitor.

module tb_wreg_dst_pipe;

  logic       clk = 1'b0;
  logic       reset_n, stall, flush, in_valid;
  logic [1:0] regdst;
  logic [5:0] rt6, rd6, sa6, sb6;

  logic [14:0] flat0; logic [2:0] vld0; logic [1:0] a0, b0;
  logic [5:0]  flat1; logic [0:0] vld1; logic [0:0] a1, b1;
  logic [29:0] flat2; logic [4:0] vld2; logic [2:0] a2, b2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wreg_dst_pipe u_dut0 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rt(rt6[4:0]), .rd(rd6[4:0]), .regdst(regdst), .src_a(sa6[4:0]), .src_b(sb6[4:0]),
    .dst_flat(flat0), .dst_vld(vld0), .fwd_a_sel(a0), .fwd_b_sel(b0)
  );

  wreg_dst_pipe #(.AW(6), .STAGES(1), .LINK_REG(63)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rt(rt6), .rd(rd6), .regdst(regdst), .src_a(sa6), .src_b(sb6),
    .dst_flat(flat1), .dst_vld(vld1), .fwd_a_sel(a1), .fwd_b_sel(b1)
  );

  wreg_dst_pipe #(.AW(6), .STAGES(5), .LINK_REG(63)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rt(rt6), .rd(rd6), .regdst(regdst), .src_a(sa6), .src_b(sb6),
    .dst_flat(flat2), .dst_vld(vld2), .fwd_a_sel(a2), .fwd_b_sel(b2)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] flat;
    logic [7:0]  vld;
    int          sa;
    int          sb;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  int p_aw[3]     = '{5, 6, 6};
  int p_stages[3] = '{3, 1, 5};
  int p_link[3]   = '{31, 63, 63};

  // Slot 0 is the youngest in-flight instruction; index k is k stages older.
  int m_dst[3][8];
  bit m_vld[3][8];

  function automatic void model_reset();
    for (int m = 0; m < 3; m++)
      for (int k = 0; k < 8; k++) begin
        m_dst[m][k] = 0;
        m_vld[m][k] = 1'b0;
      end
  endfunction

  function automatic void model_step(int m, bit st, bit fl, bit iv, int rg, int rtv, int rdv);
    int mask = (1 << p_aw[m]) - 1;
    int ns   = p_stages[m];
    int nd;
    bit nv;
    int od[8];
    bit ov[8];
    case (rg)
      0:       nd = rdv & mask;
      1:       nd = rtv & mask;
      2:       nd = p_link[m];
      default: nd = 0;
    endcase
    nv = iv && rg != 3 && nd != 0;
    for (int k = 0; k < 8; k++) begin od[k] = m_dst[m][k]; ov[k] = m_vld[m][k]; end
    // Everything older than the decode slot moves one stage on.
    for (int k = 1; k < ns; k++) begin m_dst[m][k] = od[k-1]; m_vld[m][k] = ov[k-1]; end
    if (fl) begin
      m_dst[m][0] = 0; m_vld[m][0] = 0;
    end else if (st) begin
      if (ns > 1) begin m_dst[m][1] = 0; m_vld[m][1] = 0; end
    end else begin
      m_dst[m][0] = nd; m_vld[m][0] = nv;
    end
  endfunction

  function automatic int model_fwd(int m, int src);
    if (src == 0) return 0;
    for (int k = 0; k < p_stages[m]; k++)
      if (m_vld[m][k] && m_dst[m][k] == src) return k + 1;
    return 0;
  endfunction

  function automatic exp_t model_expect(int m, int sa, int sb);
    exp_t e;
    int mask = (1 << p_aw[m]) - 1;
    e.flat = '0;
    e.vld  = '0;
    for (int k = 0; k < p_stages[m]; k++) begin
      e.flat = e.flat | (64'(m_dst[m][k]) << (k * p_aw[m]));
      e.vld[k] = m_vld[m][k];
    end
    e.sa = model_fwd(m, sa & mask);
    e.sb = model_fwd(m, sb & mask);
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic chk_vec(string name, exp_t e, logic [63:0] af, logic [7:0] av, int asa, int asb);
    vectors++;
    if (af !== e.flat || av !== e.vld || asa != e.sa || asb != e.sb) begin
      miscompares++;
      if (miscompares < 20)
        $display("FAIL %s @%0t: got flat=%0h vld=%b a=%0d b=%0d, expected flat=%0h vld=%b a=%0d b=%0d",
                 name, $time, af, av, asa, asb, e.flat, e.vld, e.sa, e.sb);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk_vec("rand_s3", e, 64'(flat0), 8'(vld0), int'(a0), int'(b0));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk_vec("rand_s1", e, 64'(flat1), 8'(vld1), int'(a1), int'(b1));
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      chk_vec("rand_s5", e, 64'(flat2), 8'(vld2), int'(a2), int'(b2));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [63:0] pk(int s0, int s1, int s2);
    logic [14:0] v;
    v = {5'(s2), 5'(s1), 5'(s0)};
    return 64'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int d);
    in_valid = 1'b1; regdst = 2'b00; rd6 = 6'(d);
    tick();
  endtask

  function automatic int rnd_reg();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
  endfunction

  initial begin
    reset_n = 1'b1; stall = 0; flush = 0; in_valid = 0; regdst = 2'b11;
    rt6 = 0; rd6 = 0; sa6 = 6'd9; sb6 = 6'd4;
    #3 reset_n = 1'b0;
    #1;
    chk("reset_flat", 64'(flat0), 64'd0);
    chk("reset_vld", 64'(vld0), 64'd0);
    chk("reset_sel", 64'({a0, b0}), 64'd0);
    tick(); tick();
    #2 reset_n = 1'b1;

    // Mode decode
    rt6 = 6'd5; rd6 = 6'd7; in_valid = 1'b1;
    regdst = 2'b00; tick(); chk("dec_rd",   64'({vld0[0], flat0[4:0]}), 64'({1'b1, 5'd7}));
    regdst = 2'b01; tick(); chk("dec_rt",   64'({vld0[0], flat0[4:0]}), 64'({1'b1, 5'd5}));
    regdst = 2'b10; tick(); chk("dec_link", 64'({vld0[0], flat0[4:0]}), 64'({1'b1, 5'd31}));
    regdst = 2'b11; tick(); chk("dec_none", 64'({vld0[0], flat0[4:0]}), 64'({1'b0, 5'd0}));
    rd6 = 6'd0; regdst = 2'b00; tick();
    chk("dec_r0_vld", 64'(vld0), 64'(3'b100));
    chk("dec_r0_flat", 64'(flat0), pk(0, 0, 31));

    // Advance and forward
    issue(9); issue(9); issue(4);
    chk("fwd_flat", 64'(flat0), pk(4, 9, 9));
    sa6 = 6'd9; sb6 = 6'd4; #1;
    chk("fwd_a_young", 64'(a0), 64'd2);
    chk("fwd_b", 64'(b0), 64'd1);
    sa6 = 6'd0; #1;
    chk("fwd_a_r0", 64'(a0), 64'd0);

    // Reset mid-run
    issue(8); issue(9); issue(10);
    chk("fill_flat", 64'(flat0), pk(10, 9, 8));
    sa6 = 6'd9;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_flat", 64'(flat0), 64'd0);
    chk("midrst_vld", 64'(vld0), 64'd0);
    chk("midrst_sel", 64'(a0), 64'd0);
    #3 reset_n = 1'b1;
    issue(3);
    chk("rel_flat", 64'(flat0), pk(3, 0, 0));
    chk("rel_vld", 64'(vld0), 64'(3'b001));

    // Stall
    issue(11); issue(12);
    stall = 1'b1; rd6 = 6'd20; tick();
    chk("stall1_flat", 64'(flat0), pk(12, 0, 11));
    chk("stall1_vld", 64'(vld0), 64'(3'b101));
    tick();
    chk("stall2_flat", 64'(flat0), pk(12, 0, 0));
    chk("stall2_vld", 64'(vld0), 64'(3'b001));
    stall = 1'b0; issue(13);
    chk("unstall_flat", 64'(flat0), pk(13, 12, 0));
    chk("unstall_vld", 64'(vld0), 64'(3'b011));

    // Flush vs stall
    issue(6);
    flush = 1'b1; stall = 1'b1; rd6 = 6'd14; tick();
    chk("fs_flat", 64'(flat0), pk(0, 6, 13));
    chk("fs_vld", 64'(vld0), 64'(3'b110));
    sa6 = 6'd6; #1;
    chk("fs_fwd", 64'(a0), 64'd2);
    stall = 1'b0; tick();
    chk("flush_flat", 64'(flat0), pk(0, 0, 6));
    chk("flush_vld", 64'(vld0), 64'(3'b100));
    sb6 = 6'd13; #1;
    chk("flush_fwd_a", 64'(a0), 64'd3);
    chk("flush_fwd_b", 64'(b0), 64'd0);
    flush = 1'b0;

    // Random phase: all three configurations against the model.
    in_valid = 0; regdst = 2'b11; stall = 0; flush = 0;
    #1 reset_n = 1'b0;
    tick();
    #2 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #2;
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      regdst   = 2'($urandom_range(0, 3));
      rt6      = 6'(rnd_reg());
      rd6      = 6'(rnd_reg());
      sa6      = 6'(rnd_reg());
      sb6      = 6'(rnd_reg());
      q0.push_back(model_expect(0, int'(sa6), int'(sb6)));
      q1.push_back(model_expect(1, int'(sa6), int'(sb6)));
      q2.push_back(model_expect(2, int'(sa6), int'(sb6)));
      for (int m = 0; m < 3; m++)
        model_step(m, stall, flush, in_valid, int'(regdst), int'(rt6), int'(rd6));
    end
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wreg_dst_pipe.md
# wreg_dst_pipe

Parametrised write-destination pipeline for the pipelined MIPS core. Each cycle it decodes an instruction's destination register from Rt/Rd/link/none. It carries that destination and a write-valid bit through STAGES pipeline slots (E, M, W by default), with stall and flush support. From the registered slots it produces per-operand forwarding selects, so the hazard unit and bypass muxes read one source of truth.

## Interface
Parameters:
- AW, 5, register address width
- STAGES, 3, number of tracked slots (slot 0 = E, slot STAGES-1 = W); legal range 1..8
- LINK_REG, 31, destination used for link mode

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset; one clock domain
- stall  in  1  hold slot 0, inject bubble into slot 1
- flush  in  1  inject bubble into slot 0
- in_valid  in  1  instruction leaving D is real (not a bubble)
- rt  in  AW  Rt field of instruction leaving D
- rd  in  AW  Rd field of instruction leaving D
- regdst  in  2  00 Rd, 01 Rt, 10 LINK_REG, 11 no write
- src_a  in  AW  first source register queried for forwarding
- src_b  in  AW  second source register queried for forwarding
- dst_flat  out  STAGES*AW  slot k destination at bits [k*AW +: AW]
- dst_vld  out  STAGES  slot k holds a register write
- fwd_a_sel  out  clog2(STAGES+1)  0 = no forward, k+1 = take slot k
- fwd_b_sel  out  clog2(STAGES+1)  same, for src_b

## Operation
- Decode, combinational on inputs:
  - new_dst = rd / rt / LINK_REG for regdst 00 / 01 / 10; 0 for 11.
  - new_vld = in_valid & (regdst != 11) & (new_dst != 0).
- A write to register 0 is never valid; its slot still records dst = 0.
- Slot update, every clock, in priority order:
  - flush = 1: slot 0 <- {dst 0, vld 0}; slots 1..STAGES-1 advance normally.
  - else stall = 1: slot 0 holds; slot 1 <- bubble {0, 0}; slots 2..STAGES-1 advance.
  - else: slot 0 <- {new_dst, new_vld}; slot k <- slot k-1 for k >= 1.
- With flush and stall both 1, flush wins for slot 0 and slot 1 still takes slot 0's old contents. A flush never kills an older instruction.
- Slot STAGES-1 contents are discarded on advance.
- If STAGES = 1, stall holds slot 0 only.
- Forwarding, combinational from registered slots only, never from the current-cycle inputs:
  - fwd_x_sel = k+1 for the lowest k with dst_vld[k] = 1 and dst slot k == src_x; the youngest match wins.
  - fwd_x_sel = 0 when src_x == 0 or there is no match.
- Bubbles have dst 0 and vld 0. They never match, and dst_flat is deterministic for checking.

## Timing
- Reset: while reset_n = 0 (asserted asynchronously), all slots clear; dst_flat = 0, dst_vld = 0, fwd_a_sel = fwd_b_sel = 0.
- Release: first update on the first rising clk after reset_n rises.
- Latency: an instruction presented with in_valid at edge n appears in slot 0 after edge n. It reaches slot k after edge n+k, assuming no stall holds it in slot 0.
- Forward selects settle in the same cycle as a change on src_a/src_b or the slot registers; no extra latency.
- Reset asserted mid-pipeline clears every slot immediately, regardless of stall/flush.
- Inputs in_valid/rt/rd/regdst are ignored in any cycle where stall or flush is 1.

## Test plan
- Reset mid-run: fill 3 slots with dst 8, 9, 10 (all vld), then pull reset_n low between edges -> dst_flat = 0 and dst_vld = 000 immediately, without waiting for a clock; first load after release appears in slot 0 only.
- Mode decode: rt = 5, rd = 7 with regdst 00 / 01 / 10 / 11 on consecutive cycles:
  - slot 0 shows 7 / 5 / 31 / 0 with vld 1 / 1 / 1 / 0.
  - then rd = 0 with regdst 00 -> vld 0.
- Advance and forward: issue dst 9, then dst 9 again, then dst 4; query src_a = 9 -> fwd_a_sel = 2 (slot 1, the youngest 9, not slot 2); src_b = 4 -> 1; src_a = 0 -> 0.
- Stall: with slot 0 = 12 and stall = 1 for 2 cycles -> slot 0 stays 12, slot 1 is a bubble both cycles, and the earlier slot-1 value is in slot 2 after the first stalled edge; on release, 12 moves to slot 1.
- Flush vs stall: slot 0 = 6 and flush = stall = 1 for one edge -> slot 0 = {0, 0} and slot 1 = 6 (vld 1); src_a = 6 -> fwd_a_sel = 2.
- Parameter sweep: STAGES = 1 and STAGES = 5, AW = 6, LINK_REG = 63. Random in_valid/regdst/stall/flush for 10k cycles -> slots and selects match a cycle-accurate reference model, and fwd_x_sel never exceeds STAGES.
